// File: rtl/i2c_master_byte.sv
// Byte-level I2C master sequencer: expands start/write/read/stop byte commands into
// single-cycle PHY bit strobes and returns one response per byte transfer.
//
// state   | meaning
// S_IDLE  | waiting for a command; cmd_ready may be high
// S_START | issuing START (or repeated START)
// S_DATA  | shifting 8 data bits out (write) or in (read)
// S_ACK   | ACK bit: read slave ACK after a write, send cmd_nack after a read
// S_STOP  | issuing STOP
// S_RESP  | response held on rsp_* until rsp_ready
module i2c_master_byte #(
   parameter bit STOP_ON_NACK = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_start,
   input  logic       cmd_write,
   input  logic       cmd_read,
   input  logic       cmd_stop,
   input  logic       cmd_nack,
   input  logic [7:0] cmd_data,
   input  logic       abort,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_nack,
   output logic       busy,
   output logic       phy_start_bit,
   output logic       phy_stop_bit,
   output logic       phy_write_bit,
   output logic       phy_read_bit,
   output logic       phy_tx_data,
   output logic       phy_release_bus,
   input  logic       phy_busy,
   input  logic       phy_rx_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_ACK   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   localparam logic [1:0] P_ISSUE = 2'd0;
   localparam logic [1:0] P_GUARD = 2'd1;
   localparam logic [1:0] P_WAIT  = 2'd2;

   logic [2:0] state_q, state_d;
   logic [1:0] step_q, step_d;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic       write_q, read_q, stop_q, nack_q;
   logic       rsp_valid_q, rsp_nack_q, release_q, live_q;
   logic [7:0] rsp_data_q;

   logic       cmd_fire, in_op, issue, op_done;
   logic       cmd_read_eff, ack_is_nack;

   function automatic logic [2:0] after_start(input logic wr, input logic rd, input logic st);
      logic [2:0] nxt;
      if (wr || rd)
         nxt = S_DATA;
      else if (st)
         nxt = S_STOP;
      else
         nxt = S_IDLE;
      return nxt;
   endfunction

   // live_q keeps cmd_ready low while reset is asserted and for the first edge after it
   assign cmd_ready    = live_q & (state_q == S_IDLE) & ~rsp_valid_q & ~abort;
   assign cmd_fire     = cmd_valid & cmd_ready;
   assign cmd_read_eff = cmd_read & ~cmd_write;
   assign in_op        = (state_q == S_START) || (state_q == S_DATA) ||
                         (state_q == S_ACK)   || (state_q == S_STOP);
   assign issue        = in_op & (step_q == P_ISSUE) & ~phy_busy & ~abort;
   assign op_done      = in_op & (step_q == P_WAIT) & ~phy_busy;
   assign ack_is_nack  = STOP_ON_NACK & write_q & phy_rx_data;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      if (abort) begin
         state_d = S_IDLE;
         step_d  = P_ISSUE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_fire) begin
                  state_d = cmd_start ? S_START : after_start(cmd_write, cmd_read_eff, cmd_stop);
                  step_d  = P_ISSUE;
               end
            end
            S_START, S_DATA, S_ACK, S_STOP: begin
               case (step_q)
                  P_ISSUE: if (issue) step_d = P_GUARD;
                  P_GUARD: step_d = P_WAIT;
                  default: begin
                     if (op_done) begin
                        step_d = P_ISSUE;
                        case (state_q)
                           S_START: state_d = after_start(write_q, read_q, stop_q);
                           S_DATA:  if (bit_cnt_q == 3'd0) state_d = S_ACK;
                           S_ACK:   state_d = (stop_q || ack_is_nack) ? S_STOP : S_RESP;
                           default: state_d = (write_q || read_q) ? S_RESP : S_IDLE;
                        endcase
                     end
                  end
               endcase
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_q      <= P_ISSUE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         stop_q      <= 1'b0;
         nack_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_nack_q  <= 1'b0;
         release_q   <= 1'b0;
         live_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         release_q <= abort;
         live_q    <= 1'b1;

         if (!abort) begin
            if (cmd_fire) begin
               write_q   <= cmd_write;
               read_q    <= cmd_read_eff;
               stop_q    <= cmd_stop;
               nack_q    <= cmd_nack;
               shift_q   <= cmd_data;
               bit_cnt_q <= 3'd7;
            end else if (op_done && state_q == S_DATA) begin
               // writes shift zeros in so a finished write leaves the register clear
               shift_q <= {shift_q[6:0], read_q & phy_rx_data};
               if (bit_cnt_q != 3'd0)
                  bit_cnt_q <= bit_cnt_q - 3'd1;
            end else if (op_done && state_q == S_ACK) begin
               rsp_nack_q <= write_q ? phy_rx_data : nack_q;
               rsp_data_q <= write_q ? 8'h00 : shift_q;
            end
         end

         if (abort)
            rsp_valid_q <= 1'b0;
         else if (state_q != S_RESP && state_d == S_RESP)
            rsp_valid_q <= 1'b1;
         else if (rsp_valid_q && rsp_ready)
            rsp_valid_q <= 1'b0;
      end
   end

   assign phy_start_bit   = issue & (state_q == S_START);
   assign phy_stop_bit    = issue & (state_q == S_STOP);
   assign phy_write_bit   = issue & (((state_q == S_DATA) & write_q) | ((state_q == S_ACK) & read_q));
   assign phy_read_bit    = issue & (((state_q == S_DATA) & read_q) | ((state_q == S_ACK) & write_q));
   assign phy_tx_data     = phy_write_bit & ((state_q == S_DATA) ? shift_q[7] : nack_q);
   assign phy_release_bus = release_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_nack  = rsp_nack_q;
   assign busy      = cmd_fire | (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte: 4-cycle PHY model plus a byte-level
// reference that predicts the strobe sequence, timing and response of each command.
module tb_i2c_master_byte;
   localparam bit SON   = 1'b1;
   localparam int BIT_T = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid, cmd_ready, cmd_start, cmd_write, cmd_read, cmd_stop, cmd_nack;
   logic [7:0] cmd_data;
   logic       abort, rsp_valid, rsp_ready, rsp_nack, busy;
   logic [7:0] rsp_data;
   logic       phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data;
   logic       phy_release_bus, phy_busy;
   logic       phy_rx_data = 1'b0;

   always #5 clk = ~clk;

   i2c_master_byte #(.STOP_ON_NACK(SON)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
      .cmd_stop(cmd_stop), .cmd_nack(cmd_nack), .cmd_data(cmd_data),
      .abort(abort),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
      .busy(busy),
      .phy_start_bit(phy_start_bit), .phy_stop_bit(phy_stop_bit),
      .phy_write_bit(phy_write_bit), .phy_read_bit(phy_read_bit),
      .phy_tx_data(phy_tx_data), .phy_release_bus(phy_release_bus),
      .phy_busy(phy_busy), .phy_rx_data(phy_rx_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // PHY model: busy for BIT_T cycles after any strobe, read bits served from rxq
   int   phy_cnt = 0;
   bit   rxq[$];
   logic any_strobe;
   assign any_strobe = phy_start_bit | phy_stop_bit | phy_write_bit | phy_read_bit;
   assign phy_busy   = (phy_cnt != 0);

   always @(posedge clk) begin
      if (!rst_n || phy_release_bus)
         phy_cnt <= 0;
      else if (any_strobe)
         phy_cnt <= BIT_T;
      else if (phy_cnt != 0)
         phy_cnt <= phy_cnt - 1;
      if (rst_n && phy_read_bit) begin
         if (rxq.size() > 0) phy_rx_data <= rxq.pop_front();
         else                phy_rx_data <= 1'b1;
      end
   end

   // strobe log: 1 start, 2 stop, 3 write 0, 4 write 1, 5 read
   int cyc = 0;
   int obs_code[$];
   int obs_cyc[$];
   int multi_cnt = 0;
   int rel_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      int n;
      n = int'(phy_start_bit) + int'(phy_stop_bit) + int'(phy_write_bit) + int'(phy_read_bit);
      if (n > 1) multi_cnt++;
      if (phy_release_bus) rel_cnt++;
      if (n > 0) begin
         obs_cyc.push_back(cyc);
         if (phy_start_bit)      obs_code.push_back(1);
         else if (phy_stop_bit)  obs_code.push_back(2);
         else if (phy_write_bit) obs_code.push_back(3 + int'(phy_tx_data));
         else                    obs_code.push_back(5);
      end
   end

   function automatic logic [31:0] out_vec();
      return {19'd0, cmd_ready, rsp_valid, rsp_data, rsp_nack, busy,
              phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus};
   endfunction

   task automatic send_cmd(input bit st, input bit wr, input bit rd, input bit sp, input bit nk,
                           input logic [7:0] d, input string name, output int hs);
      int n;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_start = st; cmd_write = wr; cmd_read = rd;
      cmd_stop = sp; cmd_nack = nk; cmd_data = d;
      hs = -1;
      n = 0;
      while (hs < 0 && n < 20) begin
         @(negedge clk);
         if (cmd_ready) begin
            hs = cyc;
            check_eq({name, ":busy_at_handshake"}, busy, 1);
         end
         n++;
      end
      check_eq({name, ":accepted"}, hs >= 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input bit st, input bit wr, input bit rd, input bit sp, input bit nk,
                          input logic [7:0] d, input logic [7:0] rx, input bit ack,
                          input int hold, input string name);
      int exp_q[$];
      bit rd_eff, has_rsp;
      logic [7:0] exp_data;
      bit exp_nack;
      int hs, n, gap_bad, stable_bad;

      rd_eff  = rd & ~wr;
      has_rsp = wr | rd_eff;
      if (st) exp_q.push_back(1);
      if (wr) begin
         for (int i = 7; i >= 0; i--) exp_q.push_back(3 + int'(d[i]));
         exp_q.push_back(5);
      end else if (rd_eff) begin
         for (int i = 0; i < 8; i++) exp_q.push_back(5);
         exp_q.push_back(3 + int'(nk));
      end
      if (sp || (SON && wr && ack)) exp_q.push_back(2);
      exp_data = rd_eff ? rx : 8'h00;
      exp_nack = wr ? ack : nk;

      rxq.delete();
      if (wr) rxq.push_back(ack);
      else if (rd_eff) for (int i = 7; i >= 0; i--) rxq.push_back(rx[i]);
      obs_code.delete();
      obs_cyc.delete();

      send_cmd(st, wr, rd, sp, nk, d, name, hs);

      if (has_rsp) begin
         n = 0;
         while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
         check_eq({name, ":rsp_valid"}, rsp_valid, 1);
      end else begin
         @(negedge clk);
         n = 1;
         while (busy && n < 400) begin @(negedge clk); n++; end
         check_eq({name, ":done"}, busy, 0);
         if (!st && !sp) check_eq({name, ":one_cycle"}, n, 1);
      end

      check_eq({name, ":n_strobes"}, obs_code.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_code.size(); i++)
         check_eq($sformatf("%s:strobe%0d", name, i), obs_code[i], exp_q[i]);
      if (obs_cyc.size() > 0) check_eq({name, ":first_latency"}, obs_cyc[0] - hs, 1);
      gap_bad = 0;
      for (int i = 1; i < obs_cyc.size(); i++)
         if (obs_cyc[i] - obs_cyc[i-1] != BIT_T + 2) gap_bad++;
      check_eq({name, ":bit_spacing"}, gap_bad, 0);

      if (has_rsp && rsp_valid) begin
         check_eq({name, ":rsp_data"}, rsp_data, exp_data);
         check_eq({name, ":rsp_nack"}, rsp_nack, exp_nack);
         stable_bad = 0;
         repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== exp_data || rsp_nack !== exp_nack || cmd_ready)
               stable_bad++;
         end
         check_eq({name, ":rsp_hold"}, stable_bad, 0);
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         @(negedge clk);
         check_eq({name, ":rsp_cleared"}, rsp_valid, 0);
         check_eq({name, ":idle_after_rsp"}, busy, 0);
      end
   endtask

   task automatic abort_test();
      int hs, n, wr_seen, rel0, bad;
      obs_code.delete();
      obs_cyc.delete();
      rxq.delete();
      rxq.push_back(1'b0);
      send_cmd(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, "abort", hs);
      wr_seen = 0;
      n = 0;
      while (wr_seen < 4 && n < 200) begin
         @(negedge clk);
         wr_seen = 0;
         foreach (obs_code[i]) if (obs_code[i] == 3 || obs_code[i] == 4) wr_seen++;
         n++;
      end
      check_eq("abort:reached_bit4", wr_seen, 4);
      rel0 = rel_cnt;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check_eq("abort:release_pulse", phy_release_bus, 1);
      check_eq("abort:busy", busy, 0);
      check_eq("abort:rsp_valid", rsp_valid, 0);
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid || busy) bad++;
      end
      check_eq("abort:quiet_after", bad, 0);
      check_eq("abort:strobes_total", obs_code.size(), 5);
      check_eq("abort:release_count", rel_cnt - rel0, 1);
   endtask

   task automatic reset_test();
      int hs, n, rd_seen;
      obs_code.delete();
      obs_cyc.delete();
      rxq.delete();
      for (int i = 0; i < 8; i++) rxq.push_back(1'b1);
      send_cmd(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "reset", hs);
      rd_seen = 0;
      n = 0;
      while (rd_seen < 4 && n < 200) begin
         @(negedge clk);
         rd_seen = 0;
         foreach (obs_code[i]) if (obs_code[i] == 5) rd_seen++;
         n++;
      end
      check_eq("reset:reached_read", rd_seen, 4);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("reset:outputs_immediate", out_vec(), 32'd0);
      obs_code.delete();
      repeat (6) @(negedge clk);
      check_eq("reset:outputs_held", out_vec(), 32'd0);
      check_eq("reset:no_strobes", obs_code.size(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, rx;
      cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0; cmd_read = 1'b0;
      cmd_stop = 1'b0; cmd_nack = 1'b0; cmd_data = 8'h00; abort = 1'b0; rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("reset:outputs", out_vec(), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("reset:ready_after", cmd_ready, 1);

      run_cmd(1, 1, 0, 0, 0, 8'hA5, 8'h00, 0, 0,  "write_a5");
      run_cmd(0, 0, 1, 1, 1, 8'h00, 8'h3C, 0, 2,  "read_3c");
      run_cmd(1, 1, 0, 0, 0, 8'h55, 8'h00, 1, 1,  "nack_stop");
      abort_test();
      run_cmd(1, 1, 0, 1, 0, 8'h96, 8'h00, 0, 0,  "after_abort");
      run_cmd(1, 0, 1, 1, 0, 8'h00, 8'hC3, 0, 10, "hold10");
      run_cmd(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,  "no_flags");
      run_cmd(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,  "start_only");
      run_cmd(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0,  "stop_only");
      run_cmd(1, 1, 1, 1, 1, 8'h3E, 8'hFF, 0, 1,  "write_ignores_read");

      for (int k = 0; k < 25; k++) begin
         d  = 8'($urandom);
         rx = 8'($urandom);
         run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 d, rx, 1'($urandom), int'($urandom_range(0, 4)), $sformatf("rand%0d", k));
      end

      reset_test();
      run_cmd(1, 0, 1, 1, 0, 8'h00, 8'h81, 0, 0, "after_reset");

      check_eq("single_strobe_per_cycle", multi_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
